m_mem_access_unit: RTL
======================

# m_mem_access_unit

Parametrised M-stage memory access unit: the successor to the purely combinational load-extension/AdEL checker. It accepts one load or store per transaction from the M stage, checks it for alignment and address-map exceptions, and drives a request/acknowledge data bus with variable latency and a timeout. It returns sign- or zero-extended load data with an exception code, and stalls the pipeline while a bus transaction is outstanding. It sits between the M-stage pipeline register and the system bridge.

## Interface
- `DATA_W`, 32: bus/data width; 32 or 64. 64 enables `LD`/`SD`.
- `ADDR_W`, 32: address width.
- `TIMEOUT`, 255: maximum cycles waiting for `m_data_ack`; must be ≥1.
- `clk` in 1: clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: M stage presents a memory op.
- `req_ready` out 1: unit accepts the op this cycle (`req_valid && req_ready` = accept).
- `req_op` in 4: operation code (`MEM_*`, package).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data, LSB-aligned.
- `flush` in 1: kill the in-flight op (exception/interrupt).
- `resp_valid` out 1: one-cycle result pulse.
- `resp_data` out DATA_W: extended load data; 0 for stores and on exceptions.
- `resp_exc` out 2: `EXC_NONE`, `EXC_ADEL`, `EXC_ADES`, `EXC_BUS`.
- `stall` out 1: high while a transaction is accepted but not yet responded.
- `m_data_req` out 1, `m_data_we` out 1, `m_data_addr` out ADDR_W (aligned to DATA_W/8), `m_data_byteen` out DATA_W/8, `m_data_wdata` out DATA_W (lane-shifted).
- `m_data_ack` in 1, `m_data_rdata` in DATA_W, `m_data_err` in 1.

## Operation
- Ops: `LB LBU LH LHU LW LWU SB SH SW`, plus `LD SD` when DATA_W=64. For DATA_W=32, `LWU`≡`LW`; `LD`/`SD` raise AdEL/AdES.
- Misalignment: H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0.
- Out of range: address outside every region in the package map (DM, TC0, TC1, UART, DigTube, Switch, Key).
- Timer/UART regions accept only word-sized accesses; anything else faults. A store to a timer `COUNT` offset (0x8) is AdES.
- Loads fault with AdEL, stores with AdES. A faulting op never raises `m_data_req`.
- Load extraction: select lane `addr[log2(DATA_W/8)-1:0]` from `m_data_rdata`; sign-extend for `LB LH LW(64)`; zero-extend for the `U` forms.
- Store: replicate data into the addressed lane; byteen is 1/2/4/8 contiguous bits at the lane offset.
- FSM:
  - IDLE: `req_ready=1`. On accept, register op/addr/wdata. If the op faults → EXC; otherwise → BUS.
  - BUS: `m_data_req=1` with all bus outputs held stable, counter increments.
    - `m_data_ack` → DONE with `resp_exc=EXC_BUS` if `m_data_err`.
    - Counter reaching TIMEOUT → DONE with `EXC_BUS`; `m_data_req` drops.
  - EXC/DONE: `resp_valid=1` for one cycle → IDLE.
- `flush` in EXC/DONE suppresses `resp_valid` and returns to IDLE.
- `flush` in BUS: the request is held until ack or timeout (the bus is never abandoned mid-handshake), then returns to IDLE with no response.

## Timing
- Reset values: state IDLE; counter 0; every output 0 except `req_ready=1`.
- Accept at cycle T.
  - Faulting op: `resp_valid` at T+1.
  - Legal op: `m_data_req` high from T+1. An ack at cycle A gives `resp_valid` at A+1. Minimum latency is 2 cycles (ack at T+1).
- `m_data_rdata` and `m_data_err` are sampled only in the ack cycle. An ack outside BUS is ignored.
- `stall` = state≠IDLE and not (state∈{EXC,DONE}).
- Ack and timeout in the same cycle: ack wins; data is used.
- `reset` mid-transaction drops `m_data_req` immediately (asynchronous). The bridge treats reset as an abort.
- Back-to-back ops: the next accept occurs in the cycle after `resp_valid`.

## Structure
- Package `mem_pkg`:
  - `MEM_*` op encodings, `EXC_*` codes.
  - Region start/end constants (`StartAddrDM` … `EndAddrKey`) and a word-only-region function.
  - Size-decode function (op → byte count).
- One sub-module, `mem_lane_ext`: combinational lane select, extension and store-lane replication/byteen, parametrised by DATA_W.

## Test plan
- DATA_W=32, `LH` at 0x0000_0002, DM returns 0x8001_1234 with ack after 3 cycles → `stall` for 4 cycles; `resp_data=0xFFFF_8001`, `EXC_NONE`.
- `LW` at 0x0000_7F01 → `resp_valid` at T+1, `EXC_ADEL`, `m_data_req` never high.
- `SB` 0xAB at 0x0000_0013 → `m_data_addr=0x10`, byteen=4'b1000, wdata=0xAB00_0000; `SH` to TC0 base → `EXC_ADES`.
- No ack, TIMEOUT=4 → `m_data_req` high for exactly 4 cycles, then `EXC_BUS`; `m_data_err` with ack → `EXC_BUS`.
- `flush` during BUS with ack 2 cycles later → no `resp_valid`; IDLE after ack; the next op is accepted cleanly.
- DATA_W=64, `LWU` at 0x4 with rdata 0x8000_0000_xxxx_xxxx → 0x0000_0000_8000_0000; async `reset` mid-BUS → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the M-stage memory access unit.
//               Holds the op and exception encodings, the system address map
//               and the helper functions that decode op size and classify
//               addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef logic [3:0] mem_op_t;
  typedef logic [1:0] mem_exc_t;

  // Bit 3 of the op code marks a store. Codes not listed here are undefined
  // and fault like a bad address.
  localparam mem_op_t MEM_LB  = 4'h0;
  localparam mem_op_t MEM_LBU = 4'h1;
  localparam mem_op_t MEM_LH  = 4'h2;
  localparam mem_op_t MEM_LHU = 4'h3;
  localparam mem_op_t MEM_LW  = 4'h4;
  localparam mem_op_t MEM_LWU = 4'h5;
  localparam mem_op_t MEM_LD  = 4'h6;
  localparam mem_op_t MEM_SB  = 4'h8;
  localparam mem_op_t MEM_SH  = 4'h9;
  localparam mem_op_t MEM_SW  = 4'hA;
  localparam mem_op_t MEM_SD  = 4'hB;

  localparam mem_exc_t EXC_NONE = 2'd0;
  localparam mem_exc_t EXC_ADEL = 2'd1;
  localparam mem_exc_t EXC_ADES = 2'd2;
  localparam mem_exc_t EXC_BUS  = 2'd3;

  // System address map (inclusive bounds).
  localparam logic [31:0] StartAddrDM      = 32'h0000_0000;
  localparam logic [31:0] EndAddrDM        = 32'h0000_2FFF;
  localparam logic [31:0] StartAddrTC0     = 32'h0000_7F00;
  localparam logic [31:0] EndAddrTC0       = 32'h0000_7F0B;
  localparam logic [31:0] StartAddrTC1     = 32'h0000_7F10;
  localparam logic [31:0] EndAddrTC1       = 32'h0000_7F1B;
  localparam logic [31:0] StartAddrUART    = 32'h0000_7F30;
  localparam logic [31:0] EndAddrUART      = 32'h0000_7F3F;
  localparam logic [31:0] StartAddrDigTube = 32'h0000_7F50;
  localparam logic [31:0] EndAddrDigTube   = 32'h0000_7F57;
  localparam logic [31:0] StartAddrSwitch  = 32'h0000_7F60;
  localparam logic [31:0] EndAddrSwitch    = 32'h0000_7F67;
  localparam logic [31:0] StartAddrKey     = 32'h0000_7F68;
  localparam logic [31:0] EndAddrKey       = 32'h0000_7F6B;

  // Offset of the read-only COUNT register inside each timer.
  localparam logic [31:0] TC_COUNT_OFS     = 32'h0000_0008;

  // Access size in bytes; 0 flags an undefined op.
  function automatic logic [3:0] mem_size(input mem_op_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 4'd1;
      MEM_LH, MEM_LHU, MEM_SH: return 4'd2;
      MEM_LW, MEM_LWU, MEM_SW: return 4'd4;
      MEM_LD, MEM_SD:          return 4'd8;
      default:                 return 4'd0;
    endcase
  endfunction

  function automatic logic mem_is_store(input mem_op_t op);
    return op[3];
  endfunction

  function automatic logic mem_is_signed(input mem_op_t op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW);
  endfunction

  function automatic logic in_range(input logic [31:0] a,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  function automatic logic in_map(input logic [31:0] a);
    return in_range(a, StartAddrDM,      EndAddrDM)      ||
           in_range(a, StartAddrTC0,     EndAddrTC0)     ||
           in_range(a, StartAddrTC1,     EndAddrTC1)     ||
           in_range(a, StartAddrUART,    EndAddrUART)    ||
           in_range(a, StartAddrDigTube, EndAddrDigTube) ||
           in_range(a, StartAddrSwitch,  EndAddrSwitch)  ||
           in_range(a, StartAddrKey,     EndAddrKey);
  endfunction

  // Timer and UART registers only decode full-word accesses.
  function automatic logic word_only_region(input logic [31:0] a);
    return in_range(a, StartAddrTC0,  EndAddrTC0)  ||
           in_range(a, StartAddrTC1,  EndAddrTC1)  ||
           in_range(a, StartAddrUART, EndAddrUART);
  endfunction

  function automatic logic is_timer_count(input logic [31:0] a);
    return (a == StartAddrTC0 + TC_COUNT_OFS) ||
           (a == StartAddrTC1 + TC_COUNT_OFS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_ext.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_ext
// Description : Combinational byte-lane steering. Shifts store data into the
//               addressed lane and builds the byte enables, and pulls the
//               addressed lane out of read data with sign/zero extension.
// Ports       : op_i     - memory op code
//               lane_i   - byte offset within the bus word
//               wdata_i  - LSB-aligned store data
//               rdata_i  - bus read data
//               byteen_o - byte enables for the store
//               wdata_o  - lane-shifted store data
//               load_o   - extracted and extended load data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_ext
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int LANE_W = $clog2(NB)
) (
  input  logic [3:0]        op_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [NB-1:0]     byteen_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] load_o
);

  logic [3:0]        size;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] shifted;
  logic              sign;

  always_comb begin
    size     = mem_size(op_i);
    mask     = '0;
    byteen_o = '0;
    shifted  = rdata_i >> {lane_i, 3'b000};
    sign     = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(size)) begin
        mask[8*i +: 8] = 8'hFF;
      end
      if ((i >= int'(lane_i)) && (i < int'(lane_i) + int'(size))) begin
        byteen_o[i] = 1'b1;
      end
      // The sign bit is the top bit of the last byte of the access.
      if (i == int'(size) - 1) begin
        sign = mem_is_signed(op_i) & shifted[8*i+7];
      end
    end
    wdata_o = (wdata_i & mask) << {lane_i, 3'b000};
    load_o  = (shifted & mask) | (sign ? ~mask : '0);
  end

endmodule
`default_nettype wire

// File: rtl/m_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : m_mem_access_unit
// Description : M-stage memory access unit. Accepts one load/store at a time,
//               checks alignment and the address map, runs a req/ack bus
//               transaction with a timeout and returns extended load data
//               with an exception code. Stalls the pipe while on the bus.
// Ports       : clk, reset         - clock, async active-high reset
//               req_*              - op handshake from the M stage
//               flush              - kill the in-flight op
//               resp_*             - one-cycle result pulse
//               stall              - bus transaction outstanding
//               m_data_*           - system bridge data bus
// Revision    : 1.0 - initial release
// ============================================================================
module m_mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                flush,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic [1:0]          resp_exc,
  output logic                stall,
  output logic                m_data_req,
  output logic                m_data_we,
  output logic [ADDR_W-1:0]   m_data_addr,
  output logic [DATA_W/8-1:0] m_data_byteen,
  output logic [DATA_W-1:0]   m_data_wdata,
  input  logic                m_data_ack,
  input  logic [DATA_W-1:0]   m_data_rdata,
  input  logic                m_data_err
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_EXC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [3:0]        op_q,      op_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [1:0]        exc_q,     exc_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic              flushed_q, flushed_d;

  // The address map is 32-bit; wider addresses must have zero upper bits.
  logic [31:0] req_addr32;
  logic        addr_hi_ok;

  generate
    if (ADDR_W > 32) begin : g_addr_wide
      assign req_addr32 = req_addr[31:0];
      assign addr_hi_ok = ~|req_addr[ADDR_W-1:32];
    end else if (ADDR_W == 32) begin : g_addr_exact
      assign req_addr32 = req_addr;
      assign addr_hi_ok = 1'b1;
    end else begin : g_addr_narrow
      assign req_addr32 = {{(32-ADDR_W){1'b0}}, req_addr};
      assign addr_hi_ok = 1'b1;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Fault check on the incoming request
  // ---------------------------------------------------------------------------
  logic [3:0] req_size;
  logic       req_store;
  logic       req_bad_op;
  logic       req_misal;
  logic       req_bad_region;
  logic       req_fault;

  always_comb begin
    req_size   = mem_size(req_op);
    req_store  = mem_is_store(req_op);
    req_bad_op = (req_size == 4'd0) || ((req_size == 4'd8) && (DATA_W == 32));
    case (req_size)
      4'd2:    req_misal = req_addr32[0];
      4'd4:    req_misal = |req_addr32[1:0];
      4'd8:    req_misal = |req_addr32[2:0];
      default: req_misal = 1'b0;
    endcase
    req_bad_region = !addr_hi_ok || !in_map(req_addr32) ||
                     (word_only_region(req_addr32) && (req_size != 4'd4)) ||
                     (req_store && is_timer_count(req_addr32));
    req_fault = req_bad_op || req_misal || req_bad_region;
  end

  // ---------------------------------------------------------------------------
  // Lane steering for the held op
  // ---------------------------------------------------------------------------
  logic [NB-1:0]     lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_load;

  mem_lane_ext #(
    .DATA_W (DATA_W)
  ) u_lane_ext (
    .op_i     (op_q),
    .lane_i   (addr_q[LANE_W-1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (m_data_rdata),
    .byteen_o (lane_be),
    .wdata_o  (lane_wdata),
    .load_o   (lane_load)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    exc_d     = exc_q;
    data_d    = data_q;
    flushed_d = flushed_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          cnt_d     = '0;
          data_d    = '0;
          flushed_d = 1'b0;
          if (req_fault) begin
            exc_d   = req_store ? EXC_ADES : EXC_ADEL;
            state_d = S_EXC;
          end else begin
            exc_d   = EXC_NONE;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // A flush cannot abandon the handshake; remember it and drop the
        // response once the bus transaction closes.
        if (flush) begin
          flushed_d = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (m_data_ack) begin
          exc_d   = m_data_err ? EXC_BUS : EXC_NONE;
          data_d  = (m_data_err || mem_is_store(op_q)) ? '0 : lane_load;
          state_d = (flush || flushed_q) ? S_IDLE : S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          exc_d   = EXC_BUS;
          data_d  = '0;
          state_d = (flush || flushed_q) ? S_IDLE : S_DONE;
        end
      end
      default: begin
        // EXC and DONE both present the response for exactly one cycle.
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      exc_q     <= EXC_NONE;
      data_q    <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      exc_q     <= exc_d;
      data_q    <= data_d;
      flushed_q <= flushed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs; bus outputs are gated by state so reset clears them at once.
  // ---------------------------------------------------------------------------
  logic in_bus;
  logic in_resp;

  assign in_bus        = (state_q == S_BUS);
  assign in_resp       = (state_q == S_EXC) || (state_q == S_DONE);

  assign req_ready     = (state_q == S_IDLE);
  assign stall         = in_bus;
  assign resp_valid    = in_resp && !flush;
  assign resp_data     = resp_valid ? data_q : '0;
  assign resp_exc      = resp_valid ? exc_q : EXC_NONE;

  assign m_data_req    = in_bus;
  assign m_data_we     = in_bus && mem_is_store(op_q);
  assign m_data_addr   = in_bus ? {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign m_data_byteen = in_bus ? lane_be : '0;
  assign m_data_wdata  = in_bus ? lane_wdata : '0;

endmodule
`default_nettype wire
